// File: rtl/ps2_pkg.sv
// PS/2 keyboard receiver shared types.
// FSM states, prefix byte codes and the queued key event.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_REL = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ps2_evt_t;

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through event queue.
// Head is forced to zero while empty so outputs are clean after reset.
module ps2_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A pop frees the slot the simultaneous push lands in.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard deserializer with E0/F0 prefix folding.
// Completed key events are queued in a small FWFT FIFO.
import ps2_pkg::*;

module ps2_kbd_rx #(
  parameter int TIMEOUT_CLK = 4000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ev_valid,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_release,
  input  logic       ev_ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CLK + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLK - 1);

  logic [1:0]  clk_sync;
  logic [1:0]  dat_sync;
  logic        clk_hist;
  logic        fall;
  logic        bit_in;

  ps2_state_e  state;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        par_bit;
  logic        par_ok;
  logic [TW-1:0] to_cnt;
  logic        timeout;
  logic        ext_pending;
  logic        rel_pending;

  logic        push_q;
  ps2_evt_t    push_ev;
  ps2_evt_t    head;
  logic        empty;
  logic        drop;

  // Idle bus is high, so sync flops reset high to avoid a false edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_hist <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      clk_hist <= clk_sync[1];
    end
  end

  assign fall    = !clk_sync[1] && clk_hist;
  assign bit_in  = dat_sync[1];
  assign par_ok  = ^{shreg, par_bit};
  assign timeout = (state != ST_IDLE) && !fall && (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      to_cnt      <= '0;
      ext_pending <= 1'b0;
      rel_pending <= 1'b0;
      frame_err   <= 1'b0;
      push_q      <= 1'b0;
      push_ev     <= '0;
    end else begin
      frame_err <= 1'b0;
      push_q    <= 1'b0;
      if (timeout) begin
        state       <= ST_IDLE;
        to_cnt      <= '0;
        frame_err   <= 1'b1;
        ext_pending <= 1'b0;
        rel_pending <= 1'b0;
      end else if (fall) begin
        to_cnt <= '0;
        unique case (state)
          ST_IDLE: begin
            if (!bit_in) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end else begin
              frame_err   <= 1'b1;
              ext_pending <= 1'b0;
              rel_pending <= 1'b0;
            end
          end
          ST_DATA: begin
            shreg <= {bit_in, shreg[7:1]};
            if (bit_cnt == 3'd7) begin
              state <= ST_PARITY;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          ST_PARITY: begin
            par_bit <= bit_in;
            state   <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (bit_in && par_ok) begin
              unique case (1'b1)
                (shreg == PS2_EXT): ext_pending <= 1'b1;
                (shreg == PS2_REL): rel_pending <= 1'b1;
                default: begin
                  push_q      <= 1'b1;
                  push_ev     <= '{ext: ext_pending,
                                   rel: rel_pending,
                                   code: shreg};
                  ext_pending <= 1'b0;
                  rel_pending <= 1'b0;
                end
              endcase
            end else begin
              frame_err   <= 1'b1;
              ext_pending <= 1'b0;
              rel_pending <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(ps2_evt_t))
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_q),
    .wr_data (push_ev),
    .pop     (ev_ready),
    .rd_data (head),
    .empty   (empty),
    .drop    (drop)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  assign ev_valid   = !empty;
  assign ev_code    = head.code;
  assign ev_ext     = head.ext;
  assign ev_release = head.rel;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed testbench for ps2_kbd_rx.
// Drives PS/2 frames bit by bit and checks queued events.
import ps2_pkg::*;

module tb_ps2_kbd_rx;

  localparam int H = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ev_ready = 1'b0;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_release;
  logic       overflow;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;

  ps2_kbd_rx dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ev_valid   (ev_valid),
    .ev_code    (ev_code),
    .ev_ext     (ev_ext),
    .ev_release (ev_release),
    .ev_ready   (ev_ready),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_err) fe_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    tick(H);
    ps2_clk = 1'b0;
    tick(H);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par,
                            input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((~^d) ^ bad_par);
    send_bit(stop);
    ps2_data = 1'b1;
    tick(H);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
  endtask

  task automatic pop();
    ev_ready = 1'b1;
    tick(1);
    ev_ready = 1'b0;
  endtask

  task automatic test_reset();
    tick(1);
    reset = 1'b1;
    tick(4);
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", ev_valid); end
    checks++; if (ev_code !== 8'h00) begin errors++; $display("FAIL rst_code got %h want 00", ev_code); end
    checks++; if (ev_ext !== 1'b0) begin errors++; $display("FAIL rst_ext got %b want 0", ev_ext); end
    checks++; if (ev_release !== 1'b0) begin errors++; $display("FAIL rst_rel got %b want 0", ev_release); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", overflow); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_ferr got %b want 0", frame_err); end
    reset = 1'b0;
    tick(4);
    checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL rst_no_edge got %0d want 0", fe_cnt); end
  endtask

  task automatic test_single();
    send_frame(8'h1C, 1'b0, 1'b1);
    checks++; if (ev_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", ev_valid); end
    checks++; if (ev_code !== 8'h1C) begin errors++; $display("FAIL single_code got %h want 1c", ev_code); end
    checks++; if (ev_ext !== 1'b0) begin errors++; $display("FAIL single_ext got %b want 0", ev_ext); end
    checks++; if (ev_release !== 1'b0) begin errors++; $display("FAIL single_rel got %b want 0", ev_release); end
    pop();
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL single_pop got %b want 0", ev_valid); end
    pop();
    checks++; if (dut.u_fifo.count !== 4'd0) begin errors++; $display("FAIL empty_pop got %0d want 0", dut.u_fifo.count); end
  endtask

  task automatic test_prefix();
    send_frame(PS2_REL, 1'b0, 1'b1);
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL f0_noevt got %b want 0", ev_valid); end
    send_frame(8'h1C, 1'b0, 1'b1);
    checks++; if (ev_code !== 8'h1C) begin errors++; $display("FAIL rel_code got %h want 1c", ev_code); end
    checks++; if (ev_release !== 1'b1) begin errors++; $display("FAIL rel_rel got %b want 1", ev_release); end
    checks++; if (ev_ext !== 1'b0) begin errors++; $display("FAIL rel_ext got %b want 0", ev_ext); end
    pop();
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL rel_one got %b want 0", ev_valid); end
    send_frame(PS2_EXT, 1'b0, 1'b1);
    send_frame(PS2_REL, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    checks++; if (ev_code !== 8'h75) begin errors++; $display("FAIL extrel_code got %h want 75", ev_code); end
    checks++; if (ev_ext !== 1'b1) begin errors++; $display("FAIL extrel_ext got %b want 1", ev_ext); end
    checks++; if (ev_release !== 1'b1) begin errors++; $display("FAIL extrel_rel got %b want 1", ev_release); end
    pop();
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL extrel_one got %b want 0", ev_valid); end
    send_frame(8'h29, 1'b0, 1'b1);
    checks++; if ({ev_ext, ev_release} !== 2'b00) begin errors++; $display("FAIL flags_clr got %b want 00", {ev_ext, ev_release}); end
    pop();
  endtask

  task automatic test_errors();
    int fe0;
    fe0 = fe_cnt;
    send_frame(8'h1C, 1'b1, 1'b1);
    checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL par_ferr got %0d want 1", fe_cnt - fe0); end
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL par_noevt got %b want 0", ev_valid); end
    send_frame(8'h32, 1'b0, 1'b1);
    checks++; if (ev_code !== 8'h32) begin errors++; $display("FAIL par_next got %h want 32", ev_code); end
    pop();
    fe0 = fe_cnt;
    send_bit(1'b1);
    tick(H);
    checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL start_ferr got %0d want 1", fe_cnt - fe0); end
    fe0 = fe_cnt;
    send_frame(8'h44, 1'b0, 1'b0);
    checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL stop_ferr got %0d want 1", fe_cnt - fe0); end
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL stop_noevt got %b want 0", ev_valid); end
    send_frame(PS2_EXT, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    checks++; if ({ev_ext, ev_code} !== 9'h01C) begin errors++; $display("FAIL err_clr got %h want 01c", {ev_ext, ev_code}); end
    pop();
  endtask

  task automatic test_timeout();
    int fe0;
    int waited;
    fe0 = fe_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    waited = 0;
    while (fe_cnt == fe0 && waited < 4200) begin
      tick(1);
      waited++;
    end
    checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL to_ferr got %0d want 1", fe_cnt - fe0); end
    checks++; if (waited < 3900 || waited > 4100) begin errors++; $display("FAIL to_delay got %0d want 3900..4100", waited); end
    checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL to_idle got %0d want 0", dut.state); end
    send_frame(8'h2B, 1'b0, 1'b1);
    checks++; if (ev_code !== 8'h2B) begin errors++; $display("FAIL to_next got %h want 2b", ev_code); end
    pop();
  endtask

  task automatic test_mid_reset();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    do_reset();
    send_frame(8'h5A, 1'b0, 1'b1);
    checks++; if ({ev_valid, ev_code} !== 9'h15A) begin errors++; $display("FAIL midrst got %h want 15a", {ev_valid, ev_code}); end
    pop();
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
    checks++; if (dut.u_fifo.count !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d want 8", dut.u_fifo.count); end
    for (int i = 1; i <= 8; i++) begin
      checks++; if (ev_code !== 8'(i)) begin errors++; $display("FAIL ovf_order got %h want %h", ev_code, 8'(i)); end
      pop();
    end
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain got %b want 0", ev_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic hit;
    do_reset();
    for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 1'b0, 1'b1);
    checks++; if (dut.u_fifo.count !== 4'd8) begin errors++; $display("FAIL fpp_fill got %0d want 8", dut.u_fifo.count); end
    hit = 1'b0;
    fork
      send_frame(8'h19, 1'b0, 1'b1);
      begin
        for (int k = 0; k < 2000 && !hit; k++) begin
          tick(1);
          if (dut.push_q) hit = 1'b1;
        end
        ev_ready = hit;
        tick(1);
        ev_ready = 1'b0;
      end
    join
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL fpp_push got %b want 1", hit); end
    checks++; if (dut.u_fifo.count !== 4'd8) begin errors++; $display("FAIL fpp_count got %0d want 8", dut.u_fifo.count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf got %b want 0", overflow); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (ev_code !== 8'h12 + 8'(i)) begin errors++; $display("FAIL fpp_order got %h want %h", ev_code, 8'h12 + 8'(i)); end
      pop();
    end
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL fpp_drain got %b want 0", ev_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_prefix();
    test_errors();
    test_timeout();
    test_mid_reset();
    test_overflow();
    test_full_push_pop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
